// File: rtl/gol_row_streamer_if.sv
// Grid-capture and row-stream signal bundle for gol_row_streamer.
// The optional grid_stable wire exists only when GOL_STREAM_STABLE_DETECT_EN is defined.
interface gol_row_streamer_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
);
  localparam int IDX_W = $clog2(ROWS);
  localparam int POP_W = $clog2(COLS + 1);
  localparam int TOT_W = $clog2(ROWS * COLS + 1);

  logic [ROWS*COLS-1:0] grid_in;
  logic                 grid_valid;
  logic                 grid_ready;
  logic [COLS-1:0]      row_data;
  logic [IDX_W-1:0]     row_idx;
  logic [POP_W-1:0]     row_pop;
  logic                 row_valid;
  logic                 row_ready;
  logic                 row_last;
  logic [TOT_W-1:0]     total_pop;
  logic [GEN_W-1:0]     gen_count;
`ifdef GOL_STREAM_STABLE_DETECT_EN
  logic                 grid_stable;
`endif

  // master: the streamer itself; slave: the upstream source and row sink.
  modport master (
    input  grid_in, grid_valid, row_ready,
    output grid_ready, row_data, row_idx, row_pop, row_valid, row_last,
           total_pop, gen_count
`ifdef GOL_STREAM_STABLE_DETECT_EN
    , output grid_stable
`endif
  );

  modport slave (
    output grid_in, grid_valid, row_ready,
    input  grid_ready, row_data, row_idx, row_pop, row_valid, row_last,
           total_pop, gen_count
`ifdef GOL_STREAM_STABLE_DETECT_EN
    , input grid_stable
`endif
  );
endinterface

// File: rtl/gol_row_streamer.sv
// Captures a 256-bit Game of Life grid and streams it as 16 rows with live-cell counts.
// Latency: first row valid 1 cycle after capture; 17-cycle minimum grid period.
// Backpressure: row_ready low freezes all row outputs; grid_ready low while streaming.
// Optional still-life detection: GOL_STREAM_STABLE_DETECT_EN.
module gol_row_streamer #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  gol_row_streamer_if.master  bus
);
  localparam int IDX_W = $clog2(ROWS);
  localparam int POP_W = $clog2(COLS + 1);
  localparam int TOT_W = $clog2(ROWS * COLS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                     state;
  logic [ROWS-1:0][COLS-1:0]  snap;
  logic [IDX_W-1:0]           idx;
  logic [COLS-1:0]            row_q;
  logic [TOT_W-1:0]           acc;
  logic [GEN_W-1:0]           gen;
  logic                       rdy_q;
  logic                       vld_q;
  logic                       last_q;
  logic [POP_W-1:0]           pop;
  logic                       xfer;
  logic [IDX_W-1:0]           idx_nxt;
`ifdef GOL_STREAM_STABLE_DETECT_EN
  logic [ROWS*COLS-1:0]       prev_snap;
  logic                       stable_q;
`endif

  assign xfer    = vld_q && bus.row_ready;
  assign idx_nxt = idx + IDX_W'(1);

  always_comb begin
    pop = '0;
    for (int i = 0; i < COLS; i++) begin
      pop = pop + POP_W'(row_q[i]);
    end
  end

  // Row r of the grid sits at snap[ROWS-1-r], so row 0 is the most significant slice.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      snap   <= '0;
      idx    <= '0;
      row_q  <= '0;
      acc    <= '0;
      gen    <= '0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
`ifdef GOL_STREAM_STABLE_DETECT_EN
      prev_snap <= '0;
      stable_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.grid_valid && rdy_q) begin
            snap   <= bus.grid_in;
            row_q  <= bus.grid_in[ROWS*COLS-1 -: COLS];
            gen    <= gen + GEN_W'(1);
            acc    <= '0;
            idx    <= '0;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b1;
            last_q <= 1'b0;
            state  <= STREAM;
`ifdef GOL_STREAM_STABLE_DETECT_EN
            // gen still holds the pre-capture count: the first grid is never stable.
            stable_q  <= (bus.grid_in == prev_snap) && (gen != '0);
            prev_snap <= bus.grid_in;
`endif
          end
        end
        STREAM: begin
          if (xfer) begin
            acc <= acc + TOT_W'(pop);
            if (last_q) begin
              vld_q  <= 1'b0;
              rdy_q  <= 1'b1;
              last_q <= 1'b0;
              state  <= IDLE;
            end else begin
              idx    <= idx_nxt;
              row_q  <= snap[LAST_IDX - idx_nxt];
              last_q <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grid_ready = rdy_q;
  assign bus.row_data   = row_q;
  assign bus.row_idx    = idx;
  assign bus.row_pop    = pop;
  assign bus.row_valid  = vld_q;
  assign bus.row_last   = last_q;
  assign bus.total_pop  = acc + TOT_W'(pop);
  assign bus.gen_count  = gen;
`ifdef GOL_STREAM_STABLE_DETECT_EN
  assign bus.grid_stable = stable_q;
`endif
endmodule

// File: tb/tb_gol_row_streamer.sv
// Directed bench for gol_row_streamer; rows are checked against a scoreboard filled at capture.
// Define GOL_STREAM_STABLE_DETECT_EN to also exercise still-life detection.
module tb_gol_row_streamer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gol_row_streamer_if #(.ROWS(16), .COLS(16), .GEN_W(16)) bus ();
  gol_row_streamer #(.ROWS(16), .COLS(16), .GEN_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [15:0] d;
    logic [3:0]  idx;
    logic [4:0]  pop;
    logic        last;
    logic [8:0]  tot;
    logic [15:0] gen;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_gen = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_grid(input logic [255:0] g, input logic [15:0] gen);
    int   run = 0;
    exp_t e;
    for (int r = 0; r < 16; r++) begin
      e.d    = g[255-16*r -: 16];
      e.idx  = 4'(r);
      e.pop  = 5'($countones(e.d));
      run   += $countones(e.d);
      e.last = (r == 15);
      e.tot  = 9'(run);
      e.gen  = gen;
      sbq.push_back(e);
    end
  endtask

  // Holds grid_valid until the capture edge; returns negedges spent waiting for grid_ready.
  task automatic send_grid(input logic [255:0] g, output int waited);
    waited = 0;
    bus.grid_in    = g;
    bus.grid_valid = 1'b1;
    @(negedge clk);
    while (!bus.grid_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("capture_timeout", 256'(waited < 100), 256'(1));
    exp_gen++;
    push_grid(g, exp_gen);
    @(posedge clk);
    #1;
    bus.grid_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.grid_ready && sbq.size() == 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 256'(n < 200), 256'(1));
  endtask

  task automatic wait_idx(input logic [3:0] k);
    int n = 0;
    while (!(bus.row_valid && bus.row_idx == k) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idx_timeout", 256'(n < 100), 256'(1));
  endtask

  task automatic count_busy(input int exp_cycles);
    int n = 0;
    while (!bus.grid_ready && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("ready_low_cycles", 256'(n), 256'(exp_cycles));
  endtask

  // Scoreboard consumer: a row transfers on the next rising edge, so sample at the falling one.
  exp_t e_mon;
  always @(negedge clk) begin
    if (reset && bus.row_valid && bus.row_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_row", 256'(sbq.size()), 256'(1));
      end else begin
        e_mon = sbq.pop_front();
        chk("row_data", 256'(bus.row_data), 256'(e_mon.d));
        chk("row_idx",  256'(bus.row_idx),  256'(e_mon.idx));
        chk("row_pop",  256'(bus.row_pop),  256'(e_mon.pop));
        chk("row_last", 256'(bus.row_last), 256'(e_mon.last));
        if (e_mon.last) begin
          chk("total_pop", 256'(bus.total_pop), 256'(e_mon.tot));
          chk("gen_count", 256'(bus.gen_count), 256'(e_mon.gen));
        end
      end
    end
  end

  logic [255:0] glider, ones, zeros, rnd, other, block;
  logic [15:0]  hold_d;
  logic [4:0]   hold_p;
  int           w;

  initial begin
    glider = '0;
    glider[255:240] = 16'h4000;
    glider[239:224] = 16'h2000;
    glider[223:208] = 16'hE000;
    ones  = '1;
    zeros = '0;
    for (int i = 0; i < 8; i++) rnd[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++) other[32*i +: 32] = $urandom;
    block = '0;
    block[255-16*7 -: 16] = 16'h0180;
    block[255-16*8 -: 16] = 16'h0180;

    reset          = 1'b0;
    bus.grid_in    = '0;
    bus.grid_valid = 1'b0;
    bus.row_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grid_ready", 256'(bus.grid_ready), 256'(1));
    chk("rst_row_valid",  256'(bus.row_valid),  256'(0));
    chk("rst_row_last",   256'(bus.row_last),   256'(0));
    chk("rst_row_idx",    256'(bus.row_idx),    256'(0));
    chk("rst_row_data",   256'(bus.row_data),   256'(0));
    chk("rst_row_pop",    256'(bus.row_pop),    256'(0));
    chk("rst_total_pop",  256'(bus.total_pop),  256'(0));
    chk("rst_gen_count",  256'(bus.gen_count),  256'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Glider: first row one cycle after capture, 16 busy cycles.
    send_grid(glider, w);
    chk("glider_first_valid", 256'(bus.row_valid), 256'(1));
    chk("glider_first_data",  256'(bus.row_data),  256'(16'h4000));
    count_busy(16);
    wait_idle();
    chk("glider_gen", 256'(bus.gen_count), 256'(1));

    // All-ones then all-zeros.
    send_grid(ones, w);
    count_busy(16);
    send_grid(zeros, w);
    count_busy(16);
    wait_idle();
    chk("zeros_gen", 256'(bus.gen_count), 256'(3));

    // Backpressure at row 7 for 5 cycles.
    send_grid(rnd, w);
    wait_idx(4'd7);
    bus.row_ready = 1'b0;
    hold_d = bus.row_data;
    hold_p = bus.row_pop;
    chk("bp_entry_data", 256'(hold_d), 256'(rnd[255-16*7 -: 16]));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data",  256'(bus.row_data),  256'(hold_d));
      chk("bp_hold_idx",   256'(bus.row_idx),   256'(7));
      chk("bp_hold_pop",   256'(bus.row_pop),   256'(hold_p));
      chk("bp_hold_valid", 256'(bus.row_valid), 256'(1));
    end
    bus.row_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_resume_idx", 256'(bus.row_idx), 256'(8));
    wait_idle();

    // A second grid offered during streaming waits for the first IDLE cycle.
    send_grid(glider, w);
    send_grid(other, w);
    chk("b2b_wait_cycles", 256'(w), 256'(16));
    wait_idle();

    // Asynchronous reset mid-stream.
    send_grid(rnd, w);
    wait_idx(4'd9);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_row_valid",  256'(bus.row_valid),  256'(0));
    chk("midrst_grid_ready", 256'(bus.grid_ready), 256'(1));
    chk("midrst_gen",        256'(bus.gen_count),  256'(0));
    sbq.delete();
    exp_gen = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_grid(glider, w);
    chk("postrst_gen", 256'(bus.gen_count), 256'(1));
    wait_idle();

`ifdef GOL_STREAM_STABLE_DETECT_EN
    send_grid(block, w);
    chk("stable_first", 256'(bus.grid_stable), 256'(0));
    wait_idle();
    send_grid(block, w);
    chk("stable_repeat", 256'(bus.grid_stable), 256'(1));
    wait_idle();
    send_grid(glider, w);
    chk("stable_changed", 256'(bus.grid_stable), 256'(0));
    wait_idle();
`endif

    repeat (3) @(posedge clk);
    chk("sb_drained", 256'(sbq.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
